// File: rtl/mul_seq_ctrl.sv
// Sequencer between EX and the two-stage array multiplier; owns HI/LO.
// Optional MADD/MSUB accumulate enabled by defining MUL_ACC_EN.
module mul_seq_ctrl #(
  parameter int          MUL_LAT  = 2,
  parameter logic [63:0] HILO_RST = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_op_i,
  input  logic [31:0] req_src1_i,
  input  logic [31:0] req_src2_i,
  output logic        mul_start_o,
  output logic        mul_sign_o,
  output logic [31:0] mul_op1_o,
  output logic [31:0] mul_op2_o,
  input  logic [63:0] mul_result_i,
  input  logic        hi_we_i,
  input  logic        lo_we_i,
  input  logic [31:0] hilo_wdata_i,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int CW = $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [63:0]   hilo;
  logic [63:0]   hilo_nx;
  logic [63:0]   res;
  logic          accept;
  logic          last;
  logic          commit;
  logic          sign_nx;

  assign accept = req_valid_i & req_ready_o & ~flush_i;
  assign last   = (cnt == CW'(MUL_LAT - 1));
  assign commit = (state == BUSY) & last & ~flush_i;

`ifdef MUL_ACC_EN
  logic [1:0] op;

  assign sign_nx = (req_op_i != 2'b01);

  always_ff @(posedge clk) begin
    if (reset)
      op <= 2'b00;
    else if (accept)
      op <= req_op_i;
  end

  // accumulate against the architectural value at the sampling edge
  always_comb begin
    res = mul_result_i;
    unique case (op)
      2'b10:   res = hilo + mul_result_i;
      2'b11:   res = hilo - mul_result_i;
      default: res = mul_result_i;
    endcase
  end
`else
  logic unused_op1;

  assign unused_op1 = req_op_i[1];
  assign sign_nx    = ~req_op_i[0];
  assign res        = mul_result_i;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    req_ready_o = 1'b0;
    mul_start_o = 1'b0;
    done_o      = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (accept)
          state_nx = BUSY;
      end
      BUSY: begin
        mul_start_o = 1'b1;
        if (flush_i)
          state_nx = IDLE;
        else if (last)
          state_nx = DONE;
      end
      DONE: begin
        done_o   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      mul_sign_o <= 1'b0;
      mul_op1_o  <= '0;
      mul_op2_o  <= '0;
    end else if (accept) begin
      cnt        <= '0;
      mul_sign_o <= sign_nx;
      mul_op1_o  <= req_src1_i;
      mul_op2_o  <= req_src2_i;
    end else if (state == BUSY) begin
      cnt <= cnt + CW'(1);
    end
  end

  // direct MTHI/MTLO writes take priority over the product per half
  always_comb begin
    hilo_nx = commit ? res : hilo;
    if (hi_we_i)
      hilo_nx[63:32] = hilo_wdata_i;
    if (lo_we_i)
      hilo_nx[31:0] = hilo_wdata_i;
  end

  always_ff @(posedge clk) begin
    if (reset)
      hilo <= HILO_RST;
    else
      hilo <= hilo_nx;
  end

  assign hi_o = hilo[63:32];
  assign lo_o = hilo[31:0];

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl with a behavioural multiplier model.
// Accumulate vectors are selected when MUL_ACC_EN is defined.
module tb_mul_seq_ctrl;

  localparam int MUL_LAT = 2;

  logic        clk;
  logic        reset;
  logic        flush_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_op_i;
  logic [31:0] req_src1_i;
  logic [31:0] req_src2_i;
  logic        mul_start_o;
  logic        mul_sign_o;
  logic [31:0] mul_op1_o;
  logic [31:0] mul_op2_o;
  logic [63:0] mul_result_i;
  logic        hi_we_i;
  logic        lo_we_i;
  logic [31:0] hilo_wdata_i;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int total  = 0;
  int passes = 0;
  int lat;
  bit sgn;

  mul_seq_ctrl #(.MUL_LAT(MUL_LAT), .HILO_RST(64'h0)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (flush_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_op_i     (req_op_i),
    .req_src1_i   (req_src1_i),
    .req_src2_i   (req_src2_i),
    .mul_start_o  (mul_start_o),
    .mul_sign_o   (mul_sign_o),
    .mul_op1_o    (mul_op1_o),
    .mul_op2_o    (mul_op2_o),
    .mul_result_i (mul_result_i),
    .hi_we_i      (hi_we_i),
    .lo_we_i      (lo_we_i),
    .hilo_wdata_i (hilo_wdata_i),
    .done_o       (done_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mul_model(
    input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] xa;
    logic [63:0] xb;
    xa = s ? {{32{a[31]}}, a} : {32'b0, a};
    xb = s ? {{32{b[31]}}, b} : {32'b0, b};
    return xa * xb;
  endfunction

  // product is garbage unless the multiplier is enabled
  assign mul_result_i = mul_start_o ?
    mul_model(mul_sign_o, mul_op1_o, mul_op2_o) : 64'h0BAD_F00D_0BAD_F00D;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_src1_i  = a;
    req_src2_i  = b;
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic wait_done(output int l, output bit s);
    l = 0;
    s = 1'b0;
    do begin
      s = s | mul_sign_o;
      tick();
      l++;
    end while (!done_o && l < 10);
  endtask

  initial begin
    reset        = 1'b1;
    flush_i      = 1'b0;
    req_valid_i  = 1'b0;
    req_op_i     = 2'b00;
    req_src1_i   = '0;
    req_src2_i   = '0;
    hi_we_i      = 1'b0;
    lo_we_i      = 1'b0;
    hilo_wdata_i = '0;
    tick();
    tick();
    chk("rst_ready", 64'(req_ready_o), 64'd1);
    chk("rst_start", 64'(mul_start_o), 64'd0);
    chk("rst_sign", 64'(mul_sign_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_ops", {mul_op1_o, mul_op2_o}, 64'h0);
    chk("rst_hilo", {hi_o, lo_o}, 64'h0);
    reset = 1'b0;
    tick();

    // signed MULT
    issue(2'b00, 32'hFFFF_FFFE, 32'h0000_0003);
    chk("mult_ready", 64'(req_ready_o), 64'd0);
    chk("mult_start", 64'(mul_start_o), 64'd1);
    chk("mult_sign", 64'(mul_sign_o), 64'd1);
    chk("mult_ops", {mul_op1_o, mul_op2_o}, 64'hFFFF_FFFE_0000_0003);
    wait_done(lat, sgn);
    chk("mult_lat", 64'(lat), 64'(MUL_LAT));
    chk("mult_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFA);
    chk("done_start", 64'(mul_start_o), 64'd0);
    tick();
    chk("post_done", 64'(done_o), 64'd0);
    chk("post_ready", 64'(req_ready_o), 64'd1);

    // unsigned MULTU
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, sgn);
    chk("multu_sign", 64'(sgn), 64'd0);
    chk("multu_hilo", {hi_o, lo_o}, 64'hFFFF_FFFE_0000_0001);
    tick();

    // back-to-back: second request held through BUSY/DONE
    issue(2'b00, 32'd2, 32'd3);
    req_valid_i = 1'b1;
    req_src1_i  = 32'd4;
    req_src2_i  = 32'd5;
    tick();
    chk("hold_busy_ready", 64'(req_ready_o), 64'd0);
    tick();
    chk("hold_done", 64'(done_o), 64'd1);
    chk("hold_done_ready", 64'(req_ready_o), 64'd0);
    chk("hold_first", {hi_o, lo_o}, 64'd6);
    tick();
    chk("hold_idle_ready", 64'(req_ready_o), 64'd1);
    chk("hold_not_yet", 64'(mul_start_o), 64'd0);
    tick();
    req_valid_i = 1'b0;
    chk("hold_accept", 64'(mul_start_o), 64'd1);
    chk("hold_op1", 64'(mul_op1_o), 64'd4);
    wait_done(lat, sgn);
    chk("hold_second", {hi_o, lo_o}, 64'd20);
    tick();

    // flush in first BUSY cycle
    issue(2'b00, 32'd5, 32'd7);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("flush_start", 64'(mul_start_o), 64'd0);
    chk("flush_ready", 64'(req_ready_o), 64'd1);
    tick();
    chk("flush_nodone", 64'(done_o), 64'd0);
    tick();
    chk("flush_nodone2", 64'(done_o), 64'd0);
    chk("flush_hilo", {hi_o, lo_o}, 64'd20);

    // flush in IDLE blocks acceptance
    flush_i     = 1'b1;
    req_valid_i = 1'b1;
    tick();
    flush_i     = 1'b0;
    req_valid_i = 1'b0;
    chk("idle_flush", 64'(mul_start_o), 64'd0);
    tick();

    // MTLO coincident with the product write
    issue(2'b00, 32'd2, 32'd3);
    tick();
    lo_we_i      = 1'b1;
    hilo_wdata_i = 32'h0000_1234;
    tick();
    lo_we_i = 1'b0;
    chk("mtlo_done", 64'(done_o), 64'd1);
    chk("mtlo_hilo", {hi_o, lo_o}, 64'h0000_0000_0000_1234);
    tick();

    // MTHI in IDLE
    hi_we_i      = 1'b1;
    hilo_wdata_i = 32'hABCD_0001;
    tick();
    hi_we_i = 1'b0;
    chk("mthi", {hi_o, lo_o}, 64'hABCD_0001_0000_1234);

    // set {HI,LO} = 0x0_00000010
    hi_we_i      = 1'b1;
    hilo_wdata_i = 32'h0;
    tick();
    hi_we_i      = 1'b0;
    lo_we_i      = 1'b1;
    hilo_wdata_i = 32'h10;
    tick();
    lo_we_i = 1'b0;
    chk("preload", {hi_o, lo_o}, 64'h10);

`ifdef MUL_ACC_EN
    issue(2'b10, 32'd3, 32'd4);
    chk("madd_sign", 64'(mul_sign_o), 64'd1);
    wait_done(lat, sgn);
    chk("madd_hilo", {hi_o, lo_o}, 64'h1C);
    tick();
    issue(2'b11, 32'h8, 32'h2);
    chk("msub_sign", 64'(mul_sign_o), 64'd1);
    wait_done(lat, sgn);
    chk("msub_hilo", {hi_o, lo_o}, 64'h0C);
    tick();
`else
    issue(2'b10, 32'd3, 32'd4);
    chk("op10_sign", 64'(mul_sign_o), 64'd1);
    wait_done(lat, sgn);
    chk("op10_hilo", {hi_o, lo_o}, 64'h0C);
    tick();
    issue(2'b11, 32'hFFFF_FFFF, 32'h2);
    chk("op11_sign", 64'(mul_sign_o), 64'd0);
    wait_done(lat, sgn);
    chk("op11_hilo", {hi_o, lo_o}, 64'h1_FFFF_FFFE);
    tick();
`endif

    // reset mid-operation
    issue(2'b00, 32'd9, 32'd9);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_start", 64'(mul_start_o), 64'd0);
    chk("midrst_ready", 64'(req_ready_o), 64'd1);
    chk("midrst_hilo", {hi_o, lo_o}, 64'h0);
    tick();
    tick();
    chk("midrst_nodone", 64'(done_o), 64'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
